// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared definitions for the dual-clock FIFO write-side and read-side
//   controllers.
//
//   FIFO_ADDR_WIDTH  default memory address width (DEPTH = 2**FIFO_ADDR_WIDTH)
//   FIFO_CODE_W      width of the generic pointer-code helpers below
//   bin2gray()       binary -> reflected Gray code
//   gray2bin()       reflected Gray code -> binary
//
//   The helpers operate on FIFO_CODE_W-bit vectors. Callers zero-extend a
//   narrower pointer on the way in and size-cast the result back down. Zero
//   upper bits map to zero upper bits in both directions, so this is exact
//   for any pointer width up to FIFO_CODE_W.
package fifo_pkg;

  localparam int unsigned FIFO_ADDR_WIDTH = 3;
  localparam int unsigned FIFO_CODE_W     = 32;

  typedef logic [FIFO_CODE_W-1:0] fifo_code_t;

  function automatic fifo_code_t bin2gray(input fifo_code_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Prefix XOR from the MSB downwards, done as log2(FIFO_CODE_W) shift steps
  function automatic fifo_code_t gray2bin(input fifo_code_t gray);
    fifo_code_t bin;
    bin = gray;
    bin = bin ^ (bin >> 1);
    bin = bin ^ (bin >> 2);
    bin = bin ^ (bin >> 4);
    bin = bin ^ (bin >> 8);
    bin = bin ^ (bin >> 16);
    return bin;
  endfunction

endpackage : fifo_pkg

// File: rtl/fifo_ptr_sync.sv
// fifo_ptr_sync
//   Multi-flop synchroniser for a Gray-coded pointer crossing into the
//   local clock domain. Gray coding guarantees at most one bit is in flight,
//   so the captured value is always either the old or the new pointer.
//
//   Parameters
//     WIDTH   pointer width
//     STAGES  number of flop stages (2 or more)
//   Ports
//     clk     destination-domain clock
//     rst_n   asynchronous active-low reset, clears every stage
//     d       asynchronous pointer from the other domain
//     q       synchronised pointer, STAGES clock edges after d
module fifo_ptr_sync #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule : fifo_ptr_sync

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl
//   Write-side controller of the dual-clock FIFO. Owns the write pointer and
//   memory write address, publishes the registered Gray write pointer to the
//   read domain, synchronises the read domain's Gray pointer and produces the
//   registered full flag. Single clock domain (WR_CLK).
//
//   Optional build macro: FIFO_WR_ALMOST_FULL_EN
//     defined   -> adds the WR_ALMOST_FULL port and Gray->binary fill logic
//     undefined -> port and logic absent, all other behaviour identical
//
//   Parameters
//     ADDR_WIDTH   memory address bits, DEPTH = 2**ADDR_WIDTH (min 2)
//     SYNC_STAGES  read-pointer synchroniser depth (2 or more)
//     AF_LEVEL     almost-full threshold in entries (almost-full build only)
//   Ports
//     WR_CLK          write-domain clock
//     WR_RST          asynchronous active-low reset
//     WR_INC          write request from the producer
//     GRAY_RD_PTR     Gray read pointer from the read domain (asynchronous)
//     WR_ADDR         memory write address
//     WR_EN_MEM       memory write enable (WR_INC & ~WR_FULL, combinational)
//     GRAY_WR_PTR     registered Gray write pointer to the read domain
//     WR_FULL         registered FIFO-full flag
//     WR_ALMOST_FULL  registered almost-full flag (almost-full build only)
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = FIFO_ADDR_WIDTH,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AF_LEVEL    = 6
) (
  input  logic                  WR_CLK,
  input  logic                  WR_RST,
  input  logic                  WR_INC,
  input  logic [ADDR_WIDTH:0]   GRAY_RD_PTR,
  output logic [ADDR_WIDTH-1:0] WR_ADDR,
  output logic                  WR_EN_MEM,
  output logic [ADDR_WIDTH:0]   GRAY_WR_PTR,
  output logic                  WR_FULL
`ifdef FIFO_WR_ALMOST_FULL_EN
  ,
  output logic                  WR_ALMOST_FULL
`endif
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  typedef logic [PTR_W-1:0] ptr_t;

  ptr_t wr_ptr;      // binary write pointer, MSB is the wrap bit
  ptr_t gray_ptr;    // registered Gray copy of wr_ptr
  logic full_q;

  ptr_t rq_sync;     // read pointer in the write domain (Gray)
  logic accept;
  ptr_t next_bin;
  ptr_t next_gray;
  ptr_t full_match;
  logic full_next;

  // Read-pointer synchroniser
  fifo_ptr_sync #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_rd_ptr_sync (
    .clk   (WR_CLK),
    .rst_n (WR_RST),
    .d     (GRAY_RD_PTR),
    .q     (rq_sync)
  );

  // Next-pointer and full evaluation
  always_comb begin
    accept    = WR_INC & ~full_q;
    next_bin  = wr_ptr + ptr_t'(accept);
    next_gray = ptr_t'(bin2gray(fifo_code_t'(next_bin)));

    // Full when the next write pointer sits exactly one lap ahead of the
    // synchronised read pointer; in Gray code that is the read pointer with
    // its top two bits inverted.
    full_match = {~rq_sync[ADDR_WIDTH:ADDR_WIDTH-1], rq_sync[ADDR_WIDTH-2:0]};
    full_next  = (next_gray == full_match);
  end

  // Pointer and flag registers. The flag is re-evaluated on every edge, not
  // only on writes, so it clears once a read-side pop reaches rq_sync.
  always_ff @(posedge WR_CLK or negedge WR_RST) begin
    if (!WR_RST) begin
      wr_ptr   <= '0;
      gray_ptr <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr   <= next_bin;
      gray_ptr <= next_gray;
      full_q   <= full_next;
    end
  end

`ifdef FIFO_WR_ALMOST_FULL_EN
  ptr_t rbin;
  ptr_t fill;
  logic af_next;
  logic af_q;

  // Fill level against the pessimistic (late) read pointer, modulo 2**PTR_W
  always_comb begin
    rbin    = ptr_t'(gray2bin(fifo_code_t'(rq_sync)));
    fill    = next_bin - rbin;
    af_next = (32'(fill) >= AF_LEVEL);
  end

  always_ff @(posedge WR_CLK or negedge WR_RST) begin
    if (!WR_RST) begin
      af_q <= 1'b0;
    end else begin
      af_q <= af_next;
    end
  end

  assign WR_ALMOST_FULL = af_q;
`endif

  assign WR_ADDR     = wr_ptr[ADDR_WIDTH-1:0];
  assign WR_EN_MEM   = accept;
  assign GRAY_WR_PTR = gray_ptr;
  assign WR_FULL     = full_q;

endmodule : fifo_wr_ctrl

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl
//   Directed bench for fifo_wr_ctrl with hand-computed expectations.
//   Almost-full checks are compiled in when FIFO_WR_ALMOST_FULL_EN is defined.
`timescale 1ns/1ps
module tb_fifo_wr_ctrl;

  localparam int unsigned AW = 3;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          inc    = 1'b0;
  logic [AW:0]   grd    = '0;
  logic [AW-1:0] wr_addr;
  logic          wr_en_mem;
  logic [AW:0]   gray_wr;
  logic          wr_full;
`ifdef FIFO_WR_ALMOST_FULL_EN
  logic          wr_af;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  fifo_wr_ctrl #(
    .ADDR_WIDTH  (AW),
    .SYNC_STAGES (2),
    .AF_LEVEL    (6)
  ) dut (
    .WR_CLK         (clk),
    .WR_RST         (rst_n),
    .WR_INC         (inc),
    .GRAY_RD_PTR    (grd),
    .WR_ADDR        (wr_addr),
    .WR_EN_MEM      (wr_en_mem),
    .GRAY_WR_PTR    (gray_wr),
    .WR_FULL        (wr_full)
`ifdef FIFO_WR_ALMOST_FULL_EN
    ,
    .WR_ALMOST_FULL (wr_af)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and step 1ns past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW:0] gray_seq [8];
    logic [AW:0] nb;
    logic [AW:0] ng;
    gray_seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                 4'b0111, 4'b0101, 4'b0100, 4'b1100};

    // Reset state
    repeat (2) tick();
    check_eq("rst_addr", 32'(wr_addr), 0);
    check_eq("rst_gray", 32'(gray_wr), 0);
    check_eq("rst_full", 32'(wr_full), 0);
    check_eq("rst_en",   32'(wr_en_mem), 0);
    rst_n = 1'b1;
    tick();

    // 1: asynchronous reset after three writes
    inc = 1'b1;
    repeat (3) tick();
    check_eq("t1_addr3", 32'(wr_addr), 3);
    check_eq("t1_gray3", 32'(gray_wr), 32'b0010);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t1_async_addr", 32'(wr_addr), 0);
    check_eq("t1_async_gray", 32'(gray_wr), 0);
    check_eq("t1_async_full", 32'(wr_full), 0);
    inc = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // 2: fill with read pointer at 0
    for (int i = 0; i < 8; i++) begin
      inc = 1'b1;
      #1;
      check_eq("t2_en", 32'(wr_en_mem), 1);
      check_eq("t2_addr", 32'(wr_addr), 32'(i));
      tick();
      check_eq("t2_gray", 32'(gray_wr), 32'(gray_seq[i]));
      check_eq("t2_full", 32'(wr_full), (i == 7) ? 1 : 0);
    end
    check_eq("t2_addr_wrap", 32'(wr_addr), 0);

    // 3: writes while full are dropped
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("t3_en", 32'(wr_en_mem), 0);
      tick();
      check_eq("t3_addr", 32'(wr_addr), 0);
      check_eq("t3_gray", 32'(gray_wr), 32'b1100);
      check_eq("t3_full", 32'(wr_full), 1);
    end
    inc = 1'b0;

    // 4: one pop; first edge captures, full clears two edges after that
    grd = 4'b0001;
    tick();
    check_eq("t4_full_e1", 32'(wr_full), 1);
    tick();
    check_eq("t4_full_e2", 32'(wr_full), 1);
    tick();
    check_eq("t4_full_e3", 32'(wr_full), 0);
    inc = 1'b1;
    #1;
    check_eq("t4_en", 32'(wr_en_mem), 1);
    check_eq("t4_addr", 32'(wr_addr), 0);
    tick();
    inc = 1'b0;
    check_eq("t4_gray", 32'(gray_wr), 32'b1101);
    check_eq("t4_refull", 32'(wr_full), 1);

    // 5: 16 writes with a trailing read pointer, full last wrap back to 0
    rst_n = 1'b0;
    grd   = '0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      nb = 4'(i + 1);
      ng = nb ^ (nb >> 1);
      inc = 1'b1;
      tick();
      inc = 1'b0;
      check_eq("t5_gray", 32'(gray_wr), 32'(ng));
      check_eq("t5_full", 32'(wr_full), 0);
      grd = ng;
      repeat (3) tick();
      check_eq("t5_full_idle", 32'(wr_full), 0);
    end
    check_eq("t5_addr_end", 32'(wr_addr), 0);
    check_eq("t5_gray_end", 32'(gray_wr), 0);

`ifdef FIFO_WR_ALMOST_FULL_EN
    // 6: almost-full threshold 6 with read pointer at 0
    rst_n = 1'b0;
    grd   = '0;
    #1;
    check_eq("t6_rst_af", 32'(wr_af), 0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      inc = 1'b1;
      tick();
      check_eq("t6_af_fill", 32'(wr_af), (i >= 5) ? 1 : 0);
    end
    inc = 1'b0;
    check_eq("t6_full", 32'(wr_full), 1);
    // Pops to fill 7, 6, 5
    grd = 4'b0001;
    repeat (3) tick();
    check_eq("t6_af_fill7", 32'(wr_af), 1);
    grd = 4'b0011;
    repeat (3) tick();
    check_eq("t6_af_fill6", 32'(wr_af), 1);
    grd = 4'b0010;
    repeat (3) tick();
    check_eq("t6_af_fill5", 32'(wr_af), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fifo_wr_ctrl
